// File: rtl/cpu_control.sv
// Microcode sequencer for the 4-bit SAP CPU: fetch/execute state register
// plus combinational decode of every bus-enable and register-load strobe.
module cpu_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       ep,
  output logic       c,
  output logic       lp,
  output logic       lm,
  output logic       er,
  output logic       ri,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       lb,
  output logic       eu,
  output logic       su,
  output logic       lf,
  output logic       lo,
  output logic       hlt,
  output logic [2:0] t_state
);

  localparam int unsigned SW = 3;

  typedef enum logic [SW-1:0] {
    FA   = 3'd0,
    FI   = 3'd1,
    EX1  = 3'd2,
    EX2  = 3'd3,
    EX3  = 3'd4,
    HALT = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t state, state_nx;

  // State register: the only sequential element in the block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FA;
    else      state <= state_nx;
  end

  // Next-state: instruction length depends only on opcode.
  always_comb begin
    state_nx = FA;
    case (state)
      FA:  state_nx = FI;
      FI:  state_nx = EX1;
      EX1: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: state_nx = EX2;
          OP_HLT:                         state_nx = HALT;
          default:                        state_nx = FA;
        endcase
      end
      EX2: begin
        if (opcode == OP_ADD || opcode == OP_SUB) state_nx = EX3;
        else                                      state_nx = FA;
      end
      EX3:     state_nx = FA;
      HALT:    state_nx = HALT;
      default: state_nx = FA;
    endcase
  end

  // Strobe decode; everything is held low while reset is asserted.
  always_comb begin
    ep = 1'b0; c  = 1'b0; lp = 1'b0; lm = 1'b0;
    er = 1'b0; ri = 1'b0; li = 1'b0; ei = 1'b0;
    la = 1'b0; ea = 1'b0; lb = 1'b0; eu = 1'b0;
    su = 1'b0; lf = 1'b0; lo = 1'b0; hlt = 1'b0;
    t_state = '0;
    if (rst) begin
      t_state = SW'(state);
      case (state)
        FA: begin
          ep = 1'b1; lm = 1'b1;
        end
        FI: begin
          er = 1'b1; li = 1'b1; c = 1'b1;
        end
        EX1: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              ei = 1'b1; lm = 1'b1;
            end
            OP_LDI: begin
              ei = 1'b1; la = 1'b1;
            end
            OP_JMP: begin
              ei = 1'b1; lp = 1'b1;
            end
            OP_JC: begin
              ei = carry_flag; lp = carry_flag;
            end
            OP_JZ: begin
              ei = zero_flag; lp = zero_flag;
            end
            OP_OUT: begin
              ea = 1'b1; lo = 1'b1;
            end
            default: ;
          endcase
        end
        EX2: begin
          case (opcode)
            OP_LDA: begin
              er = 1'b1; la = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              er = 1'b1; lb = 1'b1;
            end
            OP_STA: begin
              ea = 1'b1; ri = 1'b1;
            end
            default: ;
          endcase
        end
        EX3: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            eu = 1'b1; la = 1'b1; lf = 1'b1;
            su = (opcode == OP_SUB);
          end
        end
        HALT:    hlt = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_control.sv
// Self-checking bench for cpu_control: per-instruction vector table, halt and
// reset sequences, and randomized instruction streams against a step model.
module tb_cpu_control;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic       carry_flag = 1'b0;
  logic       zero_flag = 1'b0;
  logic ep, c, lp, lm, er, ri, li, ei, la, ea, lb, eu, su, lf, lo, hlt;
  logic [2:0] t_state;

  cpu_control dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .ep(ep), .c(c), .lp(lp), .lm(lm), .er(er), .ri(ri), .li(li), .ei(ei),
    .la(la), .ea(ea), .lb(lb), .eu(eu), .su(su), .lf(lf), .lo(lo),
    .hlt(hlt), .t_state(t_state)
  );

  always #5 clk = ~clk;

  localparam logic [15:0] EP = 16'h8000, C  = 16'h4000, LP = 16'h2000, LM = 16'h1000;
  localparam logic [15:0] ER = 16'h0800, RI = 16'h0400, LI = 16'h0200, EI = 16'h0100;
  localparam logic [15:0] LA = 16'h0080, EA = 16'h0040, LB = 16'h0020, EU = 16'h0010;
  localparam logic [15:0] SU = 16'h0008, LF = 16'h0004, LO = 16'h0002, HL = 16'h0001;

  logic [15:0] obs;
  assign obs = {ep, c, lp, lm, er, ri, li, ei, la, ea, lb, eu, su, lf, lo, hlt};

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: instruction length and strobes for step k of an instruction.
  function automatic int ref_len(input logic [3:0] op);
    case (op)
      4'h1, 4'h4: return 4;
      4'h2, 4'h3: return 5;
      default:    return 3;
    endcase
  endfunction

  function automatic logic [15:0] ref_mask(input logic [3:0] op, input logic cf,
                                           input logic zf, input int k);
    int m;
    if (k == 0) return EP | LM;
    if (k == 1) return ER | LI | C;
    m = k - 2;
    case (op)
      4'h1: return (m == 0) ? (EI | LM) : (ER | LA);
      4'h2, 4'h3: begin
        if (m == 0) return EI | LM;
        if (m == 1) return ER | LB;
        return EU | LA | LF | ((op == 4'h3) ? SU : 16'h0);
      end
      4'h4: return (m == 0) ? (EI | LM) : (EA | RI);
      4'h5: return EI | LA;
      4'h6: return EI | LP;
      4'h7: return cf ? (EI | LP) : 16'h0;
      4'h8: return zf ? (EI | LP) : 16'h0;
      4'hE: return EA | LO;
      default: return 16'h0;
    endcase
  endfunction

  // Structural invariants on every active cycle.
  always @(negedge clk) begin
    if (rst) begin
      total++;
      if ($countones({ep, er, ei, ea, eu}) > 1 || (c && lp)) begin
        bad++;
        $display("FAIL invariant: drivers=%b c=%b lp=%b want <=1 driver and not c&lp",
                 {ep, er, ei, ea, eu}, c, lp);
      end
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic        cf;
    logic        zf;
    int          len;
    logic [15:0] m2;
    logic [15:0] m3;
    logic [15:0] m4;
  } vec_t;

  vec_t vt[15];

  initial begin
    logic [15:0] exp;
    logic [3:0]  op;
    int          len;

    vt[0]  = '{4'h0, 1'b0, 1'b0, 3, 16'h0, 16'h0, 16'h0};
    vt[1]  = '{4'h1, 1'b0, 1'b0, 4, EI | LM, ER | LA, 16'h0};
    vt[2]  = '{4'h2, 1'b1, 1'b1, 5, EI | LM, ER | LB, EU | LA | LF};
    vt[3]  = '{4'h3, 1'b0, 1'b0, 5, EI | LM, ER | LB, EU | LA | LF | SU};
    vt[4]  = '{4'h4, 1'b0, 1'b0, 4, EI | LM, EA | RI, 16'h0};
    vt[5]  = '{4'h5, 1'b0, 1'b0, 3, EI | LA, 16'h0, 16'h0};
    vt[6]  = '{4'h6, 1'b0, 1'b0, 3, EI | LP, 16'h0, 16'h0};
    vt[7]  = '{4'h7, 1'b1, 1'b0, 3, EI | LP, 16'h0, 16'h0};
    vt[8]  = '{4'h7, 1'b0, 1'b1, 3, 16'h0, 16'h0, 16'h0};
    vt[9]  = '{4'h8, 1'b0, 1'b1, 3, EI | LP, 16'h0, 16'h0};
    vt[10] = '{4'h8, 1'b1, 1'b0, 3, 16'h0, 16'h0, 16'h0};
    vt[11] = '{4'h9, 1'b1, 1'b1, 3, 16'h0, 16'h0, 16'h0};
    vt[12] = '{4'hD, 1'b1, 1'b1, 3, 16'h0, 16'h0, 16'h0};
    vt[13] = '{4'hE, 1'b0, 1'b0, 3, EA | LO, 16'h0, 16'h0};
    vt[14] = '{4'hC, 1'b0, 1'b1, 3, 16'h0, 16'h0, 16'h0};

    // Reset held for three cycles.
    repeat (3) cycle();
    chk("reset_strobes", 32'(obs), 32'h0);
    chk("reset_tstate", 32'(t_state), 32'h0);
    rst = 1'b1;

    // Table: one instruction per record, checked each cycle.
    for (int i = 0; i < 15; i++) begin
      for (int k = 0; k < vt[i].len; k++) begin
        opcode = vt[i].op; carry_flag = vt[i].cf; zero_flag = vt[i].zf;
        #1;
        exp = (k == 0) ? (EP | LM) : (k == 1) ? (ER | LI | C) :
              (k == 2) ? vt[i].m2 : (k == 3) ? vt[i].m3 : vt[i].m4;
        chk($sformatf("vec%0d_op%0h_t%0d", i, vt[i].op, k), 32'(obs), 32'(exp));
        chk($sformatf("vec%0d_op%0h_ts%0d", i, vt[i].op, k), 32'(t_state), 32'(k));
        cycle();
      end
      chk($sformatf("vec%0d_back_to_fa", i), 32'(t_state), 32'h0);
    end

    // Halt: three cycles, then frozen regardless of opcode.
    opcode = 4'hF;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("hlt_t%0d", k), 32'(obs), 32'(ref_mask(4'hF, 1'b0, 1'b0, k)));
      cycle();
    end
    for (int n = 0; n < 20; n++) begin
      opcode = 4'($urandom_range(0, 15));
      carry_flag = 1'($urandom); zero_flag = 1'($urandom);
      #1;
      chk("halt_tstate", 32'(t_state), 32'h7);
      chk("halt_strobes", 32'(obs), 32'(HL));
      cycle();
    end
    rst = 1'b0;
    #1;
    chk("halt_reset_async_strobes", 32'(obs), 32'h0);
    chk("halt_reset_async_tstate", 32'(t_state), 32'h0);
    cycle();
    rst = 1'b1;
    #1;
    chk("halt_resume_fa", 32'(obs), 32'(EP | LM));
    cycle();

    // Wait for current FA->FI path to settle back to an instruction boundary.
    opcode = 4'h0;
    #1;
    chk("resume_fi", 32'(t_state), 32'h1);
    repeat (2) cycle();

    // Reset asserted in EX2 of LDA.
    opcode = 4'h1;
    repeat (3) cycle();
    chk("lda_ex2_strobes", 32'(obs), 32'(ER | LA));
    chk("lda_ex2_tstate", 32'(t_state), 32'h3);
    rst = 1'b0;
    #1;
    chk("mid_reset_strobes", 32'(obs), 32'h0);
    chk("mid_reset_tstate", 32'(t_state), 32'h0);
    cycle();
    rst = 1'b1;
    #1;
    chk("mid_restart_fa", 32'(obs), 32'(EP | LM));
    cycle();
    chk("mid_restart_fi", 32'(t_state), 32'h1);
    repeat (3) cycle();

    // Random instruction stream; opcode is free during fetch, flags vary each cycle.
    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      len = ref_len(op);
      for (int k = 0; k < len; k++) begin
        opcode = (k < 2) ? 4'($urandom_range(0, 15)) : op;
        carry_flag = 1'($urandom); zero_flag = 1'($urandom);
        #1;
        chk($sformatf("rnd%0d_op%0h_t%0d", i, op, k), 32'(obs),
            32'(ref_mask(op, carry_flag, zero_flag, k)));
        chk($sformatf("rnd%0d_op%0h_ts%0d", i, op, k), 32'(t_state), 32'(k));
        cycle();
      end
      if (op == 4'hF) begin
        opcode = 4'($urandom_range(0, 15));
        #1;
        chk($sformatf("rnd%0d_halted", i), 32'({t_state, obs}), 32'({3'd7, HL}));
        rst = 1'b0;
        #1;
        chk($sformatf("rnd%0d_halt_reset", i), 32'({t_state, obs}), 32'h0);
        rst = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_control.md
# cpu_control

Microcode sequencer for the 4-bit SAP CPU. It steps a fetch/execute state machine and drives every bus-enable and register-load strobe: the program counter's load (`lp`) and count (`c`) inputs, the MAR, RAM, IR, A, B, ALU, flags and output registers. It reads the IR opcode and the ALU flags, and is the sole initiator of all bus transfers.

## Interface
- Parameters: none.
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `opcode`  in  4  IR upper nibble; must be stable in EX1..EX3.
- `carry_flag`, `zero_flag`  in  1 each  registered ALU flags.
- `ep`  out  1  PC drives bus.
- `c`  out  1  PC increment.
- `lp`  out  1  PC load from bus.
- `lm`  out  1  MAR load.
- `er`  out  1  RAM drives bus.
- `ri`  out  1  RAM write from bus.
- `li`  out  1  IR load.
- `ei`  out  1  IR operand nibble drives bus.
- `la`, `ea`  out  1 each  A load / A drives bus.
- `lb`  out  1  B load.
- `eu`, `su`  out  1 each  ALU drives bus / subtract select.
- `lf`  out  1  flags load.
- `lo`  out  1  output register load.
- `hlt`  out  1  CPU halted.
- `t_state`  out  3  current state encoding, for debug.

## Operation
- States and `t_state` codes: FA=0 (fetch address), FI=1 (fetch instruction), EX1=2, EX2=3, EX3=4, HALT=7. Codes 5 and 6 are unused; if entered, the next state is FA.
- FA: `ep`, `lm`. Next state FI.
- FI: `er`, `li`, `c`. Next state EX1.
- Execute microcode, per opcode. The listed signals apply in each state. After the last state shown, the next state is FA.
  - 0 NOP: EX1: none.
  - 1 LDA: EX1: `ei`,`lm`. EX2: `er`,`la`.
  - 2 ADD: EX1: `ei`,`lm`. EX2: `er`,`lb`. EX3: `eu`,`la`,`lf`.
  - 3 SUB: as ADD, with `su` also asserted in EX3.
  - 4 STA: EX1: `ei`,`lm`. EX2: `ea`,`ri`.
  - 5 LDI: EX1: `ei`,`la`.
  - 6 JMP: EX1: `ei`,`lp`.
  - 7 JC: EX1: `ei`,`lp` only if `carry_flag`=1; otherwise none.
  - 8 JZ: EX1: as JC, conditioned on `zero_flag`.
  - E OUT: EX1: `ea`,`lo`.
  - F HLT: EX1: none. Next state HALT.
  - 9–D: undefined; treated as NOP.
- HALT: every strobe is 0 and `hlt`=1. The block stays in HALT until reset.
- Exactly one bus driver (`ep`,`er`,`ei`,`ea`,`eu`) is asserted in any state, or none.
- `c` and `lp` are never asserted in the same cycle.
- Strobes are combinational from state, `opcode` and flags. The state register is the only sequential element.
- Jump flags are sampled combinationally in EX1. A flag change mid-EX1 has effect only if it is stable before the rising edge.

## Timing
- While `rst`=0: state forced to FA, and all outputs are forced to 0, including `t_state`=0 and `hlt`=0.
- Reset release: first rising edge after `rst` goes high executes FA, so the PC (reset to 0) is placed in the MAR.
- Instruction lengths, including the 2 fetch cycles:
  - NOP, LDI, JMP, JC, JZ, OUT, undefined: 3 cycles.
  - LDA, STA: 4 cycles.
  - ADD, SUB: 5 cycles.
  - HLT: 3 cycles to reach HALT.
- The PC increments at the end of FI. A jump loads the PC at the end of EX1, overriding that increment for the next fetch.
- PC wrap-around (15→0) is the PC's concern; the controller needs no special case.
- Reset asserted mid-instruction: outputs drop to 0 immediately, asynchronously. No partial instruction completes.
- Reset asserted in HALT: leaves HALT and restarts at FA.

## Test plan
- Reset/fetch: hold `rst`=0 for 3 cycles → all outputs 0. Release with `opcode`=0 → `t_state` sequence 0,1,2,0. `ep`/`lm` high in cycle 1, `er`/`li`/`c` high in cycle 2.
- ADD timing: `opcode`=2 → `t_state` 0,1,2,3,4,0. EX3 asserts `eu`,`la`,`lf` with `su`=0. Repeat with `opcode`=3 → `su`=1 in EX3 only.
- Conditional jumps: `opcode`=7 with `carry_flag`=1 → `ei`,`lp` in EX1. Same with `carry_flag`=0 → no strobes in EX1, and the next state is FA. Repeat for `opcode`=8 with `zero_flag`.
- STA/OUT: `opcode`=4 → EX2 has `ea`,`ri` and no other driver. `opcode`=E → EX1 has `ea`,`lo`, and the instruction is 3 cycles.
- Halt: `opcode`=F → after EX1, `t_state`=7 and `hlt`=1. The state is unchanged over 20 cycles with varying `opcode`. Pulse `rst` low → `hlt` goes to 0 asynchronously, and the block resumes at FA.
- Mid-instruction reset and invariants: assert `rst` in EX2 of LDA → outputs 0 in the same cycle, restart at FA. A bench assertion over random opcodes and flags checks ≤1 bus driver asserted and never `c`&`lp` together.
